// File: rtl/music_seq.sv
// music_seq: song sequencer stepping note codes at TICK_HZ and driving a square-wave buzzer.
// Build option: define MUSIC_SEQ_LOAD_EN to add a run-time write port into the song memory.
module music_seq #(
   parameter int    CLK_HZ     = 25000000,
   parameter int    TICK_HZ    = 16,
   parameter int    NUM_SONGS  = 2,
   parameter int    SONG_DEPTH = 512,
   parameter int    NOTE_W     = 6,
   parameter string SONG_FILE  = "songs.txt",
   localparam int   SEL_W      = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
   localparam int   IDX_W      = $clog2(SONG_DEPTH),
   localparam int   ADDR_W     = $clog2(NUM_SONGS * SONG_DEPTH)
) (
   input  logic              IN_clk,
   input  logic              IN_rst,
`ifdef MUSIC_SEQ_LOAD_EN
   input  logic              IN_wr_en,
   input  logic [ADDR_W-1:0] IN_wr_addr,
   input  logic [NOTE_W-1:0] IN_wr_data,
`endif
   input  logic [SEL_W-1:0]  IN_song_sel,
   input  logic              IN_play,
   input  logic              IN_start,
   input  logic              IN_stop,
   input  logic              IN_loop,
   output logic              OUT_music,
   output logic              OUT_busy,
   output logic              OUT_done,
   output logic [IDX_W-1:0]  OUT_index,
   output logic [NOTE_W-1:0] OUT_note
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int TK_W     = $clog2(TICK_DIV);
   localparam int HP_W     = $clog2(CLK_HZ / 524 + 1);
   localparam logic [NOTE_W-1:0] REST = NOTE_W'(21);
   localparam logic [NOTE_W-1:0] ENDM = NOTE_W'(22);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

   // Half-period minus one, so the tone counter compares directly against the table.
   function automatic int hp_m1_of(input int k);
      int f;
      f = 494;
      case (k % 7)
         0:       f = 262;
         1:       f = 294;
         2:       f = 330;
         3:       f = 349;
         4:       f = 392;
         5:       f = 440;
         default: f = 494;
      endcase
      f = f << (k / 7);
      return (k < 21) ? (CLK_HZ / (2 * f)) - 1 : 0;
   endfunction

   logic [HP_W-1:0] hp_tab [0:31];
   for (genvar k = 0; k < 32; k++) begin : g_hp
      assign hp_tab[k] = HP_W'(hp_m1_of(k));
   end

   logic [NOTE_W-1:0] mem [0:NUM_SONGS*SONG_DEPTH-1];

   initial begin
      for (int i = 0; i < NUM_SONGS * SONG_DEPTH; i++) mem[i] = REST;
   end

`ifdef MUSIC_SEQ_LOAD_EN
   always_ff @(posedge IN_clk) begin
      if (IN_wr_en) mem[IN_wr_addr] <= IN_wr_data;
   end
`endif

   state_t            state_q;
   logic [TK_W-1:0]   tick_cnt;
   logic [HP_W-1:0]   tone_cnt;
   logic [IDX_W-1:0]  index_q;
   logic [SEL_W-1:0]  song_q;
   logic [NOTE_W-1:0] note_q;
   logic [NOTE_W-1:0] mem_q;
   logic              ld_q;
   logic              music_q;
   logic              busy_q;
   logic              done_q;

   logic              last_idx;
   logic              tick_now;
   logic              end_mark;
   logic              wrap_now;
   logic              end_now;
   logic              fin_now;
   logic              is_tone;
   logic [HP_W-1:0]   hp_cur;
   logic [IDX_W-1:0]  rd_idx;
   logic [SEL_W-1:0]  rd_song;
   logic [ADDR_W-1:0] rd_addr;

   // The read address tracks the index the FSM is about to adopt, so mem_q holds
   // the new entry exactly one cycle after a start, tick or loop wrap (ld_q).
   always_comb begin
      last_idx = (index_q == IDX_W'(SONG_DEPTH - 1));
      tick_now = (state_q == S_PLAY) && IN_play && (tick_cnt == TK_W'(TICK_DIV - 1));
      end_mark = ld_q && (mem_q == ENDM);
      wrap_now = end_mark && IN_loop && (index_q != '0);
      end_now  = end_mark && !wrap_now;
      fin_now  = !IN_start && (end_now || (tick_now && last_idx && !IN_loop));
      is_tone  = (note_q < NOTE_W'(21));
      hp_cur   = hp_tab[note_q[4:0]];
      rd_song  = IN_start ? IN_song_sel : song_q;
      if (IN_start || wrap_now) rd_idx = '0;
      else if (tick_now)        rd_idx = last_idx ? '0 : index_q + 1'b1;
      else                      rd_idx = index_q;
      rd_addr  = ADDR_W'(rd_song) * ADDR_W'(SONG_DEPTH) + ADDR_W'(rd_idx);
   end

   always_ff @(posedge IN_clk) begin
      mem_q <= mem[rd_addr];
   end

   always_ff @(posedge IN_clk) begin
      done_q <= 1'b0;
      if (state_q == S_PLAY && is_tone) begin
         if (tone_cnt == hp_cur) begin
            tone_cnt <= '0;
            music_q  <= ~music_q;
         end else begin
            tone_cnt <= tone_cnt + 1'b1;
         end
      end else begin
         music_q <= 1'b0;
         if (state_q != S_PAUSE) tone_cnt <= '0;
      end

      if (IN_rst) begin
         state_q  <= S_IDLE;
         tick_cnt <= '0;
         tone_cnt <= '0;
         index_q  <= '0;
         song_q   <= '0;
         note_q   <= REST;
         ld_q     <= 1'b0;
         music_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (IN_stop || fin_now) begin
         state_q  <= S_IDLE;
         tick_cnt <= '0;
         tone_cnt <= '0;
         index_q  <= '0;
         note_q   <= REST;
         ld_q     <= 1'b0;
         music_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= !IN_stop && !IN_loop;
      end else if (IN_start) begin
         state_q  <= IN_play ? S_PLAY : S_PAUSE;
         tick_cnt <= '0;
         index_q  <= '0;
         song_q   <= IN_song_sel;
         ld_q     <= 1'b1;
         busy_q   <= 1'b1;
      end else begin
         ld_q <= 1'b0;
         case (state_q)
            S_PLAY: begin
               if (!IN_play) begin
                  state_q  <= S_PAUSE;
                  tone_cnt <= tone_cnt;
                  music_q  <= 1'b0;
               end else if (tick_now) begin
                  tick_cnt <= '0;
                  index_q  <= last_idx ? '0 : index_q + 1'b1;
                  ld_q     <= 1'b1;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            S_PAUSE: if (IN_play) state_q <= S_PLAY;
            default: ;
         endcase
         // A note change restarts the tone from a low phase; equal codes keep sounding.
         if (wrap_now) begin
            index_q <= '0;
            ld_q    <= 1'b1;
         end else if (ld_q && (mem_q != note_q)) begin
            note_q   <= mem_q;
            tone_cnt <= '0;
            music_q  <= 1'b0;
         end
      end
   end

   assign OUT_music = music_q;
   assign OUT_busy  = busy_q;
   assign OUT_done  = done_q;
   assign OUT_index = index_q;
   assign OUT_note  = note_q;

endmodule
